line_write_merge_buffer: RTL and testbench

- Single-entry write-combining buffer between the LC-3b CPU data port and physical memory; the write-direction counterpart of the line-to-word read extractor.
- Merges 16-bit CPU word writes with byte enables into a 128-bit line image plus a 16-bit byte-valid mask.
- Drains the whole line to physical memory in one masked line write, triggered by a write to another line, a full mask, or an explicit flush.

---
 rtl/line_write_merge_buffer.sv | 143 ++++++++++++++
 tb/tb_line_write_merge_buffer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/line_write_merge_buffer.sv
// Single-entry write-combining buffer: merges 16-bit CPU byte-enabled writes into
// one 128-bit line and drains it to physical memory as one masked line write.
module line_write_merge_buffer #(
   parameter int LINE_BYTES  = 16,
   parameter int OFFSET_BITS = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         mem_write,
   input  logic [15:0]  mem_address,
   input  logic [15:0]  mem_wdata,
   input  logic [1:0]   mem_byte_enable,
   output logic         mem_resp,
   input  logic         flush,
   output logic         flush_done,
   output logic         pmem_write,
   output logic [15:0]  pmem_address,
   output logic [127:0] pmem_wdata,
   output logic [15:0]  pmem_byte_mask,
   input  logic         pmem_resp
);

   typedef enum logic [1:0] {EMPTY = 2'd0, HOLD = 2'd1, DRAIN = 2'd2} state_t;

   state_t                      state_r;
   logic [15-OFFSET_BITS:0]     tag_r;
   logic [8*LINE_BYTES-1:0]     line_r;
   logic [LINE_BYTES-1:0]       mask_r;
   logic                        pmem_write_r;

   logic [15-OFFSET_BITS:0]     tag_s;
   logic                        hit_s;
   logic [LINE_BYTES-1:0]       en_s;
   logic [8*LINE_BYTES-1:0]     data_s;
   logic [8*LINE_BYTES-1:0]     bitmask_s;
   logic [8*LINE_BYTES-1:0]     base_line_s;
   logic [LINE_BYTES-1:0]       base_mask_s;
   logic [8*LINE_BYTES-1:0]     new_line_s;
   logic [LINE_BYTES-1:0]       new_mask_s;
   logic                        mem_resp_s;
   logic                        flush_done_s;

   assign tag_s       = mem_address[15:OFFSET_BITS];
   assign hit_s       = (tag_s == tag_r);
   assign en_s        = {{(LINE_BYTES-2){1'b0}}, mem_byte_enable} << {mem_address[3:1], 1'b0};
   assign data_s      = {{(8*LINE_BYTES-16){1'b0}}, mem_wdata} << {mem_address[3:1], 4'b0000};
   // A fresh line starts from zero so stale bytes of the previous line never leak out.
   assign base_line_s = (state_r == EMPTY) ? {(8*LINE_BYTES){1'b0}} : line_r;
   assign base_mask_s = (state_r == EMPTY) ? {LINE_BYTES{1'b0}} : mask_r;

   // Expand per-byte enables into a bit mask and merge the write into the line image.
   always_comb begin
      bitmask_s = {(8*LINE_BYTES){1'b0}};
      for (int i = 0; i < LINE_BYTES; i++) begin
         bitmask_s[8*i +: 8] = {8{en_s[i]}};
      end
      new_line_s = (base_line_s & ~bitmask_s) | (data_s & bitmask_s);
      new_mask_s = base_mask_s | en_s;
   end

   // Same-cycle handshake outputs decoded from the current state.
   always_comb begin
      mem_resp_s   = 1'b0;
      flush_done_s = 1'b0;
      case (state_r)
         EMPTY: begin
            mem_resp_s   = mem_write;
            flush_done_s = flush;
         end
         HOLD: begin
            mem_resp_s   = mem_write & ~flush & hit_s;
            flush_done_s = 1'b0;
         end
         DRAIN: begin
            mem_resp_s   = 1'b0;
            flush_done_s = flush & pmem_resp;
         end
         default: begin
            mem_resp_s   = 1'b0;
            flush_done_s = 1'b0;
         end
      endcase
   end

   // Buffer state machine: capture, merge, and drain the line.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= EMPTY;
         tag_r        <= {(16-OFFSET_BITS){1'b0}};
         line_r       <= {(8*LINE_BYTES){1'b0}};
         mask_r       <= {LINE_BYTES{1'b0}};
         pmem_write_r <= 1'b0;
      end else begin
         case (state_r)
            EMPTY: begin
               if (mem_write && (mem_byte_enable != 2'b00)) begin
                  tag_r   <= tag_s;
                  line_r  <= new_line_s;
                  mask_r  <= new_mask_s;
                  state_r <= HOLD;
               end
            end
            HOLD: begin
               if (flush) begin
                  state_r      <= DRAIN;
                  pmem_write_r <= 1'b1;
               end else if (mem_write && hit_s) begin
                  line_r <= new_line_s;
                  mask_r <= new_mask_s;
                  if (new_mask_s == {LINE_BYTES{1'b1}}) begin
                     state_r      <= DRAIN;
                     pmem_write_r <= 1'b1;
                  end
               end else if (mem_write) begin
                  // Conflicting line: the request stays pending until the buffer is empty.
                  state_r      <= DRAIN;
                  pmem_write_r <= 1'b1;
               end
            end
            DRAIN: begin
               if (pmem_resp) begin
                  mask_r       <= {LINE_BYTES{1'b0}};
                  state_r      <= EMPTY;
                  pmem_write_r <= 1'b0;
               end
            end
            default: begin
               state_r      <= EMPTY;
               mask_r       <= {LINE_BYTES{1'b0}};
               pmem_write_r <= 1'b0;
            end
         endcase
      end
   end

   assign mem_resp       = mem_resp_s;
   assign flush_done     = flush_done_s;
   assign pmem_write     = pmem_write_r;
   assign pmem_address   = {tag_r, {OFFSET_BITS{1'b0}}};
   assign pmem_wdata     = line_r;
   assign pmem_byte_mask = mask_r;

endmodule

// File: tb/tb_line_write_merge_buffer.sv
// Directed, table-driven bench for line_write_merge_buffer with hand-computed expectations.
module tb_line_write_merge_buffer;

   logic         clk;
   logic         rst;
   logic         mem_write;
   logic [15:0]  mem_address;
   logic [15:0]  mem_wdata;
   logic [1:0]   mem_byte_enable;
   logic         mem_resp;
   logic         flush;
   logic         flush_done;
   logic         pmem_write;
   logic [15:0]  pmem_address;
   logic [127:0] pmem_wdata;
   logic [15:0]  pmem_byte_mask;
   logic         pmem_resp;

   int checks = 0;
   int errors = 0;

   line_write_merge_buffer dut (
      .clk            (clk),
      .rst            (rst),
      .mem_write      (mem_write),
      .mem_address    (mem_address),
      .mem_wdata      (mem_wdata),
      .mem_byte_enable(mem_byte_enable),
      .mem_resp       (mem_resp),
      .flush          (flush),
      .flush_done     (flush_done),
      .pmem_write     (pmem_write),
      .pmem_address   (pmem_address),
      .pmem_wdata     (pmem_wdata),
      .pmem_byte_mask (pmem_byte_mask),
      .pmem_resp      (pmem_resp)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic         wr;
      logic [15:0]  addr;
      logic [15:0]  wd;
      logic [1:0]   be;
      logic         fl;
      logic         pr;
      logic         e_resp;
      logic         e_done;
      logic         e_pw;
      logic [15:0]  e_pa;
      logic [15:0]  e_mask;
      logic [127:0] e_line;
   } vec_t;

   vec_t tbl [17];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                        input logic [1:0] be, input logic fl, input logic pr);
      mem_write       = wr;
      mem_address     = addr;
      mem_wdata       = wd;
      mem_byte_enable = be;
      flush           = fl;
      pmem_resp       = pr;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // wr addr wdata be fl pr | resp done pw paddr mask line
      tbl[0]  = '{1'b1, 16'h1234, 16'hBEEF, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 128'h0};
      tbl[1]  = '{1'b1, 16'h1230, 16'h00AA, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1230, 16'h0030, 128'h0000_BEEF_0000_0000};
      tbl[2]  = '{1'b1, 16'h1231, 16'h5500, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1230, 16'h0031, 128'h0000_BEEF_0000_00AA};
      tbl[3]  = '{1'b1, 16'h2000, 16'h1111, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1230, 16'h0033, 128'h0000_BEEF_0000_55AA};
      tbl[4]  = '{1'b1, 16'h2000, 16'h1111, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1230, 16'h0033, 128'h0000_BEEF_0000_55AA};
      tbl[5]  = '{1'b1, 16'h2000, 16'h1111, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1230, 16'h0033, 128'h0000_BEEF_0000_55AA};
      tbl[6]  = '{1'b1, 16'h2000, 16'h1111, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1230, 16'h0033, 128'h0000_BEEF_0000_55AA};
      tbl[7]  = '{1'b1, 16'h2000, 16'h1111, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1230, 16'h0000, 128'h0000_BEEF_0000_55AA};
      tbl[8]  = '{1'b0, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h2000, 16'h0003, 128'h1111};
      tbl[9]  = '{1'b1, 16'h2002, 16'h2222, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h2000, 16'h0003, 128'h1111};
      tbl[10] = '{1'b1, 16'h2002, 16'h2222, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h2000, 16'h0003, 128'h1111};
      tbl[11] = '{1'b1, 16'h2002, 16'h2222, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h2000, 16'h0000, 128'h1111};
      tbl[12] = '{1'b0, 16'h0000, 16'h0000, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h2000, 16'h000C, 128'h2222_0000};
      tbl[13] = '{1'b0, 16'h0000, 16'h0000, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h2000, 16'h000C, 128'h2222_0000};
      tbl[14] = '{1'b0, 16'h0000, 16'h0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h2000, 16'h0000, 128'h2222_0000};
      tbl[15] = '{1'b1, 16'h3000, 16'h7777, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h2000, 16'h0000, 128'h2222_0000};
      tbl[16] = '{1'b0, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h2000, 16'h0000, 128'h2222_0000};

      rst = 1'b1;
      drive(1'b0, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b0);
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("reset_resp",  {127'b0, mem_resp},   128'h0);
      chk("reset_done",  {127'b0, flush_done}, 128'h0);
      chk("reset_pw",    {127'b0, pmem_write}, 128'h0);
      chk("reset_paddr", {112'b0, pmem_address},   128'h0);
      chk("reset_mask",  {112'b0, pmem_byte_mask}, 128'h0);
      chk("reset_line",  pmem_wdata, 128'h0);

      for (int i = 0; i < 17; i++) begin
         drive(tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].be, tbl[i].fl, tbl[i].pr);
         chk($sformatf("row%0d_resp", i),  {127'b0, mem_resp},   {127'b0, tbl[i].e_resp});
         chk($sformatf("row%0d_done", i),  {127'b0, flush_done}, {127'b0, tbl[i].e_done});
         chk($sformatf("row%0d_pw", i),    {127'b0, pmem_write}, {127'b0, tbl[i].e_pw});
         chk($sformatf("row%0d_paddr", i), {112'b0, pmem_address},   {112'b0, tbl[i].e_pa});
         chk($sformatf("row%0d_mask", i),  {112'b0, pmem_byte_mask}, {112'b0, tbl[i].e_mask});
         chk($sformatf("row%0d_line", i),  pmem_wdata, tbl[i].e_line);
         tick();
      end

      // Eight word writes fill the line and force a drain on the full mask.
      for (int i = 0; i < 8; i++) begin
         logic [15:0] a;
         logic [15:0] d;
         a = 16'h4000 + 16'(2 * i);
         d = 16'h1111 * 16'(i + 1);
         drive(1'b1, a, d, 2'b11, 1'b0, 1'b0);
         chk($sformatf("fill%0d_resp", i), {127'b0, mem_resp}, 128'h1);
         chk($sformatf("fill%0d_pw", i),   {127'b0, pmem_write}, 128'h0);
         tick();
      end
      drive(1'b0, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b0);
      chk("full_pw",    {127'b0, pmem_write}, 128'h1);
      chk("full_mask",  {112'b0, pmem_byte_mask}, 128'hFFFF);
      chk("full_paddr", {112'b0, pmem_address}, 128'h4000);
      chk("full_line",  pmem_wdata, 128'h8888_7777_6666_5555_4444_3333_2222_1111);
      tick();
      chk("full_pw_hold", {127'b0, pmem_write}, 128'h1);

      // Reset in the middle of the drain abandons the line.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("rstdrain_pw",    {127'b0, pmem_write}, 128'h0);
      chk("rstdrain_mask",  {112'b0, pmem_byte_mask}, 128'h0);
      chk("rstdrain_paddr", {112'b0, pmem_address}, 128'h0);
      chk("rstdrain_line",  pmem_wdata, 128'h0);
      drive(1'b0, 16'h0000, 16'h0000, 2'b00, 1'b1, 1'b0);
      chk("rstdrain_empty_flush", {127'b0, flush_done}, 128'h1);
      drive(1'b1, 16'h5002, 16'h1234, 2'b00, 1'b0, 1'b0);
      chk("be00_resp", {127'b0, mem_resp}, 128'h1);
      tick();
      drive(1'b0, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b0);
      chk("be00_mask",  {112'b0, pmem_byte_mask}, 128'h0);
      chk("be00_paddr", {112'b0, pmem_address}, 128'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
